// File: rtl/acc_cpu_pkg.sv
// Shared types and encodings for the 16-bit accumulator CPU: opcodes, datapath
// select codes, sequencer states and the decoded-control bundle.
package acc_cpu_pkg;

    localparam int INSTR_W   = 16;
    localparam int OPC_W_DEF = 5;
    localparam int OPND_W    = INSTR_W - OPC_W_DEF;

    typedef enum logic [4:0] {
        OPC_HLT  = 5'd0,
        OPC_STO  = 5'd1,
        OPC_LD   = 5'd2,
        OPC_LDI  = 5'd3,
        OPC_ADD  = 5'd4,
        OPC_ADDI = 5'd5,
        OPC_SUB  = 5'd6,
        OPC_SUBI = 5'd7
    } opcode_t;

    localparam logic [1:0] SELA_MEM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;

    localparam logic SELB_MEM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_EXEC1     = 3'd3,
        ST_EXEC2     = 3'd4,
        ST_HALT      = 3'd5,
        ST_WAIT_STEP = 3'd6
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       uses_rd;
        logic       uses_wr;
        logic       writes_acc;
        logic       is_halt;
    } dec_t;

endpackage

// File: rtl/acc_decoder.sv
// Combinational opcode decoder: maps the IR opcode field to datapath selects,
// ALU op and the memory/accumulator strobe enables. Unlisted opcodes are NOPs.
module acc_decoder
    import acc_cpu_pkg::*;
#(
    parameter int OPC_W = OPC_W_DEF
) (
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec
);

    always_comb begin
        dec = '0;
        case (32'(opcode))
            32'(OPC_HLT): dec.is_halt = 1'b1;
            32'(OPC_STO): dec.uses_wr = 1'b1;
            32'(OPC_LD): begin
                dec.sel_a      = SELA_MEM;
                dec.uses_rd    = 1'b1;
                dec.writes_acc = 1'b1;
            end
            32'(OPC_LDI): begin
                dec.sel_a      = SELA_IMM;
                dec.writes_acc = 1'b1;
            end
            32'(OPC_ADD): begin
                dec.sel_a      = SELA_ALU;
                dec.sel_b      = SELB_MEM;
                dec.op         = OP_ADD;
                dec.uses_rd    = 1'b1;
                dec.writes_acc = 1'b1;
            end
            32'(OPC_ADDI): begin
                dec.sel_a      = SELA_ALU;
                dec.sel_b      = SELB_IMM;
                dec.op         = OP_ADD;
                dec.writes_acc = 1'b1;
            end
            32'(OPC_SUB): begin
                dec.sel_a      = SELA_ALU;
                dec.sel_b      = SELB_MEM;
                dec.op         = OP_SUB;
                dec.uses_rd    = 1'b1;
                dec.writes_acc = 1'b1;
            end
            32'(OPC_SUBI): begin
                dec.sel_a      = SELA_ALU;
                dec.sel_b      = SELB_IMM;
                dec.op         = OP_SUB;
                dec.writes_acc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_control_unit.sv
// Fetch/decode/execute sequencer for the accumulator datapath; owns PC, IR and halt.
// Optional build macro SINGLE_STEP_EN adds the Step input and the WAIT_STEP state.
module acc_control_unit
    import acc_cpu_pkg::*;
#(
    parameter int PC_W  = 11,
    parameter int OPC_W = OPC_W_DEF
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    output logic [PC_W-1:0]         InstrAddr,
    output logic                    InstrRd,
    input  logic [INSTR_W-1:0]      Instr,
    output logic [1:0]              SelA,
    output logic                    SelB,
    output logic [INSTR_W-OPC_W-1:0] Addr,
    output logic                    WrAcc,
    output logic                    Op,
    output logic                    RdRam,
    output logic                    WrRam,
    output logic                    Busy,
    output logic                    Halted,
`ifdef SINGLE_STEP_EN
    input  logic                    Step,
`endif
    output state_t                  DbgState
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    dec_t                 dec;

    acc_decoder #(.OPC_W(OPC_W)) u_dec (
        .opcode (ir_q[INSTR_W-1 -: OPC_W]),
        .dec    (dec)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Strobes are single-cycle, one-shot requests with no back-pressure:
    // InstrRd in FETCH (word valid in LOAD), RdRam/WrRam in EXEC1 (read data
    // valid in EXEC2), WrAcc in EXEC2. Selects are held through both EXEC
    // cycles so the datapath mux/ALU is settled at the WrAcc edge.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        InstrAddr = pc_q;
        InstrRd   = 1'b0;
        SelA      = SELA_MEM;
        SelB      = SELB_MEM;
        Op        = OP_ADD;
        Addr      = '0;
        WrAcc     = 1'b0;
        RdRam     = 1'b0;
        WrRam     = 1'b0;
        Busy      = 1'b1;
        Halted    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                InstrRd = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ir_d    = Instr;
                state_d = ST_EXEC1;
            end
            ST_EXEC1: begin
                Addr    = ir_q[INSTR_W-OPC_W-1:0];
                SelA    = dec.sel_a;
                SelB    = dec.sel_b;
                Op      = dec.op;
                RdRam   = dec.uses_rd;
                WrRam   = dec.uses_wr;
                state_d = ST_EXEC2;
            end
            ST_EXEC2: begin
                Addr  = ir_q[INSTR_W-OPC_W-1:0];
                SelA  = dec.sel_a;
                SelB  = dec.sel_b;
                Op    = dec.op;
                WrAcc = dec.writes_acc;
                if (dec.is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = pc_q + PC_ONE;
`ifdef SINGLE_STEP_EN
                    state_d = ST_WAIT_STEP;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_HALT: begin
                Busy   = 1'b0;
                Halted = 1'b1;
                if (Start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_WAIT_STEP: begin
`ifdef SINGLE_STEP_EN
                if (Step) state_d = ST_FETCH;
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                Busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign DbgState = state_q;

endmodule

// File: tb/tb_acc_control_unit.sv
// Self-checking bench for acc_control_unit: table-driven per-opcode vectors plus
// directed program sequences against a small ROM/RAM/accumulator model.
module tb_acc_control_unit;
    import acc_cpu_pkg::*;

`ifdef SINGLE_STEP_EN
    localparam int CPI = 5;
`else
    localparam int CPI = 4;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Start2 = 1'b0;
    logic [15:0] Instr;
    logic [15:0] Instr2;

    logic [10:0] InstrAddr;
    logic        InstrRd, SelB, WrAcc, Op, RdRam, WrRam, Busy, Halted;
    logic [1:0]  SelA;
    logic [10:0] Addr;
    state_t      DbgState;

    logic [2:0]  InstrAddr2;
    logic        InstrRd2, SelB2, WrAcc2, Op2, RdRam2, WrRam2, Busy2, Halted2;
    logic [1:0]  SelA2;
    logic [10:0] Addr2;
    state_t      DbgState2;
`ifdef SINGLE_STEP_EN
    logic        Step = 1'b0;
`endif

    always #5 Clock = ~Clock;

    acc_control_unit dut (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .InstrAddr(InstrAddr), .InstrRd(InstrRd), .Instr(Instr),
        .SelA(SelA), .SelB(SelB), .Addr(Addr), .WrAcc(WrAcc), .Op(Op),
        .RdRam(RdRam), .WrRam(WrRam), .Busy(Busy), .Halted(Halted),
`ifdef SINGLE_STEP_EN
        .Step(Step),
`endif
        .DbgState(DbgState)
    );

    acc_control_unit #(.PC_W(3)) dut_w3 (
        .Clock(Clock), .Reset(Reset), .Start(Start2),
        .InstrAddr(InstrAddr2), .InstrRd(InstrRd2), .Instr(Instr2),
        .SelA(SelA2), .SelB(SelB2), .Addr(Addr2), .WrAcc(WrAcc2), .Op(Op2),
        .RdRam(RdRam2), .WrRam(WrRam2), .Busy(Busy2), .Halted(Halted2),
`ifdef SINGLE_STEP_EN
        .Step(Step),
`endif
        .DbgState(DbgState2)
    );

    // ---------------- memory / datapath model ----------------
    logic [15:0] rom [0:2047];
    logic [15:0] mem [0:2047];
    logic [15:0] ram_q, acc, imm, opb, acc_next;

    always @(posedge Clock) if (InstrRd) Instr <= rom[InstrAddr];
    always @(posedge Clock) if (InstrRd2) Instr2 <= 16'h4000;  // NOP (opcode 8)

    always_comb begin
        imm = {5'b0, Addr};
        opb = SelB ? imm : ram_q;
        case (SelA)
            2'd0:    acc_next = ram_q;
            2'd1:    acc_next = imm;
            default: acc_next = Op ? (acc - opb) : (acc + opb);
        endcase
    end

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc   <= '0;
            ram_q <= '0;
        end else begin
            if (RdRam) ram_q <= mem[Addr];
            if (WrAcc) acc <= acc_next;
        end
    end

    // ---------------- scoreboard ----------------
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];       // expected STO write data
    logic [15:0] exp_addr_q[$];  // expected STO write address
    logic [15:0] pc_q[$];        // expected fetch addresses (PC_W=3 unit)

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] a);
        return {o, a};
    endfunction

    function automatic logic [31:0] all_outs();
        return {InstrAddr, InstrRd, SelA, SelB, Addr, WrAcc, Op, RdRam, WrRam, Busy, Halted};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
        if (WrRam) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wrram", 32'(Addr), 32'hFFFF_FFFF);
            end else begin
                chk("sto_addr", 32'(Addr), 32'(exp_addr_q.pop_front()));
                chk("sto_data", 32'(acc), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic tick_gap();
        tick();
`ifdef SINGLE_STEP_EN
        tick();
`endif
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        Start  = 1'b0;
        Start2 = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]  opc;
        logic [10:0] opnd;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        op;
        logic        rd;
        logic        wr;
        logic        wacc;
        logic        halt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{5'd0,  11'h123, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{5'd1,  11'h014, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{5'd2,  11'h007, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{5'd3,  11'h005, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{5'd4,  11'h7FF, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{5'd5,  11'h003, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{5'd6,  11'h400, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{5'd7,  11'h0AA, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{5'd8,  11'h555, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{5'd31, 11'h7FF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 2048; i++) begin
            rom[i] = 16'hF800;
            mem[i] = 16'h0000;
        end

        // reset state
        do_reset();
        chk("reset_outs", all_outs(), 32'h0);
        chk("reset_state", 32'(DbgState), 32'(ST_IDLE));
        chk("reset_w3", {29'b0, Busy2, Halted2, InstrRd2}, 32'h0);

        // per-opcode vectors, each instruction at PC=0
        for (int i = 0; i < 10; i++) begin
            do_reset();
            rom[0] = ins(vecs[i].opc, vecs[i].opnd);
            if (vecs[i].wr) begin
                exp_addr_q.push_back(16'(vecs[i].opnd));
                exp_q.push_back(16'h0000);
            end
            pulse_start();
            chk($sformatf("v%0d_fetch", i), {InstrRd, RdRam, WrRam, WrAcc, 17'b0, InstrAddr}, {4'b1000, 28'h0});
            tick();
            chk($sformatf("v%0d_load", i), {28'b0, InstrRd, RdRam, WrRam, WrAcc}, {31'b0, 1'b0} | {31'b0, 1'b0});
            tick();
            chk($sformatf("v%0d_exec1_strobes", i), {28'b0, InstrRd, RdRam, WrRam, WrAcc},
                {28'b0, 1'b0, vecs[i].rd, vecs[i].wr, 1'b0});
            chk($sformatf("v%0d_exec1_ctrl", i), {17'b0, SelA, SelB, Op, Addr},
                {17'b0, vecs[i].sel_a, vecs[i].sel_b, vecs[i].op, vecs[i].opnd});
            tick();
            chk($sformatf("v%0d_exec2_strobes", i), {28'b0, InstrRd, RdRam, WrRam, WrAcc},
                {28'b0, 3'b000, vecs[i].wacc});
            chk($sformatf("v%0d_exec2_ctrl", i), {17'b0, SelA, SelB, Op, Addr},
                {17'b0, vecs[i].sel_a, vecs[i].sel_b, vecs[i].op, vecs[i].opnd});
            tick();
            if (vecs[i].halt) begin
                chk($sformatf("v%0d_halted", i), {19'b0, Halted, Busy, InstrAddr}, {19'b0, 2'b10, 11'd0});
            end else begin
`ifdef SINGLE_STEP_EN
                chk($sformatf("v%0d_wait_step", i), {30'b0, InstrRd, Busy}, 32'h1);
                Step = 1'b1;
                tick();
                Step = 1'b0;
`endif
                chk($sformatf("v%0d_next_fetch", i), {20'b0, InstrRd, InstrAddr}, {20'b0, 1'b1, 11'd1});
            end
        end
        chk("vec_sto_drained", 32'(exp_q.size()), 32'h0);

        // reset mid-EXEC1 of ADD (at PC=1), then restart from PC=0
`ifdef SINGLE_STEP_EN
        Step = 1'b1;
`endif
        do_reset();
        rom[0] = ins(5'd8, 11'h0);
        rom[1] = ins(5'd4, 11'd5);
        pulse_start();
        tick(); tick(); tick();
        tick_gap();
        chk("rst_fetch_pc1", {20'b0, InstrRd, InstrAddr}, {20'b0, 1'b1, 11'd1});
        tick(); tick();
        chk("rst_pre_exec1_rd", {31'b0, RdRam}, 32'h1);
        #2 Reset = 1'b1;
        #1;
        chk("rst_async_outs", all_outs(), 32'h0);
        chk("rst_async_state", 32'(DbgState), 32'(ST_IDLE));
        @(posedge Clock);
        #1;
        chk("rst_next_state", 32'(DbgState), 32'(ST_IDLE));
        Reset = 1'b0;
        pulse_start();
        chk("rst_restart_fetch", {20'b0, InstrRd, InstrAddr}, {20'b0, 1'b1, 11'd0});

        // {LDI 5, ADDI 3, STO 20, HLT}
        do_reset();
        rom[0] = ins(5'd3, 11'd5);
        rom[1] = ins(5'd5, 11'd3);
        rom[2] = ins(5'd1, 11'd20);
        rom[3] = ins(5'd0, 11'd0);
        exp_addr_q.push_back(16'd20);
        exp_q.push_back(16'd8);
        pulse_start();
        repeat (3 * CPI + 3) tick();
        chk("p1_not_yet_halted", {31'b0, Halted}, 32'h0);
        tick();
        chk("p1_halted", {19'b0, Halted, Busy, InstrAddr}, {19'b0, 2'b10, 11'd3});
        chk("p1_acc", 32'(acc), 32'd8);
        chk("p1_sto_drained", 32'(exp_q.size()), 32'h0);

        // {LD 7, SUB 8, HLT}, mem[7]=10, mem[8]=4
        do_reset();
        rom[0] = ins(5'd2, 11'd7);
        rom[1] = ins(5'd6, 11'd8);
        rom[2] = ins(5'd0, 11'd0);
        mem[7] = 16'd10;
        mem[8] = 16'd4;
        pulse_start();
        tick(); tick();
        chk("p2_ld_exec1", {17'b0, InstrRd, RdRam, WrRam, WrAcc, Addr}, {17'b0, 4'b0100, 11'd7});
        tick();
        chk("p2_ld_exec2", {26'b0, InstrRd, RdRam, WrRam, WrAcc, SelA}, {26'b0, 4'b0001, 2'd0});
        tick_gap(); tick(); tick();
        chk("p2_sub_exec1", {17'b0, InstrRd, RdRam, WrRam, WrAcc, Addr}, {17'b0, 4'b0100, 11'd8});
        chk("p2_acc_after_ld", 32'(acc), 32'd10);
        tick();
        chk("p2_sub_exec2", {24'b0, InstrRd, RdRam, WrRam, WrAcc, SelA, SelB, Op},
            {24'b0, 4'b0001, 2'd2, 1'b0, 1'b1});
        tick_gap(); tick(); tick(); tick(); tick();
        chk("p2_acc", 32'(acc), 32'd6);
        chk("p2_halted", {31'b0, Halted}, 32'h1);

`ifdef SINGLE_STEP_EN
        // LDI 1 parks in WAIT_STEP until Step
        Step = 1'b0;
        do_reset();
        rom[0] = ins(5'd3, 11'd1);
        pulse_start();
        tick(); tick(); tick(); tick();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("ss_wait_%0d", k), {30'b0, InstrRd, Busy}, 32'h1);
            tick();
        end
        Step = 1'b1;
        tick();
        Step = 1'b0;
        chk("ss_step_fetch", {20'b0, InstrRd, InstrAddr}, {20'b0, 1'b1, 11'd1});
        Step = 1'b1;
`endif

        // PC_W=3 NOP ROM: wrap 0..7,0 while Start pulses during Busy are ignored
        do_reset();
        for (int a = 0; a < 8; a++) pc_q.push_back(16'(a));
        pc_q.push_back(16'd0);
        Start2 = 1'b1;
        tick();
        Start2 = 1'b0;
        cyc = 0;
        while (pc_q.size() > 0 && cyc < 80) begin
            if (InstrRd2) chk("w3_fetch_addr", 32'(InstrAddr2), 32'(pc_q.pop_front()));
            if (cyc == 10 || cyc == 23) begin
                chk("w3_busy_at_start", {31'b0, Busy2}, 32'h1);
                Start2 = 1'b1;
            end else begin
                Start2 = 1'b0;
            end
            tick();
            cyc++;
        end
        Start2 = 1'b0;
        chk("w3_fetch_drained", 32'(pc_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
